// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared BCD digit and packed MM:SS.CC time types
package stopwatch_pkg;
  typedef logic [3:0] bcd_t;
  typedef struct packed {
    bcd_t m_tens;
    bcd_t m_ones;
    bcd_t s_tens;
    bcd_t s_ones;
    bcd_t c_tens;
    bcd_t c_ones;
  } time_t;
  localparam bcd_t BCD_MAX9 = 4'd9;
  localparam bcd_t BCD_MAX5 = 4'd5;
  localparam time_t ZERO_TIME = '0;
endpackage

// File: rtl/stopwatch_timer_bcd_digit.sv
// bcd_digit: mod-(MAX+1) BCD counter cell with ripple carry
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX9
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_cin,
  output bcd_t o_digit,
  output logic o_cout
);
  bcd_t digit_q, digit_d;
  // out-of-range values fall back to 0 on the next carry-in
  always_comb digit_d = i_clr ? '0 : !i_cin ? digit_q : (digit_q >= MAX) ? '0 : digit_q + 4'd1;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) digit_q <= '0;
    else digit_q <= digit_d;
  end
  assign o_digit = digit_q;
  assign o_cout  = i_cin && (digit_q == MAX);
endmodule

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: 1/100 s prescaler and BCD MM:SS.CC counter; lap capture under STOPWATCH_LAP_EN
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic        i_lap,
  output logic [23:0] o_time,
  output logic        o_tick,
  output logic        o_wrap,
  output logic [23:0] o_lap_time,
  output logic        o_lap_valid
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  logic [PW-1:0] pre_q, pre_d;
  logic tick_d, tick_q, wrap_d, wrap_q;
  logic [6:0] cy;
  bcd_t dig [6];
  time_t now;
  assign tick_d = i_en && !i_clr && (pre_q == PW'(DIV - 1));
  assign cy[0]  = tick_d;
  // digit order: c_ones, c_tens, s_ones, s_tens, m_ones, m_tens
  for (genvar i = 0; i < 6; i++) begin : g_dig
    bcd_digit #(.MAX((i == 3 || i == 5) ? BCD_MAX5 : BCD_MAX9)) u_dig (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_clr  (i_clr),
      .i_cin  (cy[i]),
      .o_digit(dig[i]),
      .o_cout (cy[i+1])
    );
  end
  assign now    = {dig[5], dig[4], dig[3], dig[2], dig[1], dig[0]};
  assign wrap_d = cy[6];
  always_comb pre_d = (i_clr || tick_d) ? '0 : i_en ? pre_q + 1'b1 : pre_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end
  assign o_time = now;
  assign o_tick = tick_q;
  assign o_wrap = wrap_q;
`ifdef STOPWATCH_LAP_EN
  time_t lap_q, lap_d;
  logic lap_valid_q, lap_valid_d;
  // sampling now before the edge latches the pre-tick value on a coincident tick
  always_comb begin
    lap_d       = i_clr ? ZERO_TIME : i_lap ? now : lap_q;
    lap_valid_d = !i_clr && (i_lap || lap_valid_q);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lap_q       <= ZERO_TIME;
      lap_valid_q <= 1'b0;
    end else begin
      lap_q       <= lap_d;
      lap_valid_q <= lap_valid_d;
    end
  end
  assign o_lap_time  = lap_q;
  assign o_lap_valid = lap_valid_q;
`else
  logic unused_lap;
  assign unused_lap  = i_lap;
  assign o_lap_time  = '0;
  assign o_lap_valid = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer: directed checks of stopwatch_timer with DIV=10
module tb_stopwatch_timer;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, clr = 1'b0, lap = 1'b0;
  logic [23:0] o_time, o_lap_time;
  logic o_tick, o_wrap, o_lap_valid;
  logic [23:0] pv;
  int n_run = 0, n_fail = 0;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif
  always #5 clk = ~clk;
  stopwatch_timer #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_clr      (clr),
    .i_lap      (lap),
    .o_time     (o_time),
    .o_tick     (o_tick),
    .o_wrap     (o_wrap),
    .o_lap_time (o_lap_time),
    .o_lap_valid(o_lap_valid)
  );
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic preload(input logic [23:0] v);
    en  = 1'b0;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    pv  = v;
    force dut.g_dig[0].u_dig.digit_q = pv[3:0];
    force dut.g_dig[1].u_dig.digit_q = pv[7:4];
    force dut.g_dig[2].u_dig.digit_q = pv[11:8];
    force dut.g_dig[3].u_dig.digit_q = pv[15:12];
    force dut.g_dig[4].u_dig.digit_q = pv[19:16];
    force dut.g_dig[5].u_dig.digit_q = pv[23:20];
    cyc(1);
    release dut.g_dig[0].u_dig.digit_q;
    release dut.g_dig[1].u_dig.digit_q;
    release dut.g_dig[2].u_dig.digit_q;
    release dut.g_dig[3].u_dig.digit_q;
    release dut.g_dig[4].u_dig.digit_q;
    release dut.g_dig[5].u_dig.digit_q;
    chk("preload", o_time, v);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("rst_time", o_time, 24'h0);
      chk("rst_tick", 24'(o_tick), 24'h0);
      chk("rst_wrap", 24'(o_wrap), 24'h0);
      chk("rst_lapv", 24'(o_lap_valid), 24'h0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      cyc(1);
      chk("basic_tick", 24'(o_tick), 24'(i % 10 == 0));
    end
    chk("basic_time", o_time, 24'h000010);
    clr = 1'b1;
    cyc(1);
    chk("clr_time", o_time, 24'h0);
    clr = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      cyc(1);
      chk("run1_tick", 24'(o_tick), 24'(i == 10));
    end
    chk("run1_time", o_time, 24'h000001);
    en = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      chk("pause_tick", 24'(o_tick), 24'h0);
    end
    chk("pause_time", o_time, 24'h000001);
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      chk("resume_tick", 24'(o_tick), 24'(i == 5));
    end
    chk("resume_time", o_time, 24'h000002);
    preload(24'h005999);
    en = 1'b1;
    cyc(9);
    chk("c59_hold", o_time, 24'h005999);
    chk("c59_notick", 24'(o_tick), 24'h0);
    cyc(1);
    chk("c59_time", o_time, 24'h010000);
    chk("c59_tick", 24'(o_tick), 24'h1);
    chk("c59_nowrap", 24'(o_wrap), 24'h0);
    preload(24'h595999);
    en = 1'b1;
    cyc(9);
    chk("wrap_pre_tick", 24'(o_tick), 24'h0);
    cyc(1);
    chk("wrap_time", o_time, 24'h000000);
    chk("wrap_tick", 24'(o_tick), 24'h1);
    chk("wrap_wrap", 24'(o_wrap), 24'h1);
    cyc(1);
    chk("wrap_one_cycle", 24'(o_wrap), 24'h0);
    chk("wrap_tick_one", 24'(o_tick), 24'h0);
    preload(24'h001234);
    en = 1'b1;
    cyc(5);
    chk("clrp_pre", o_time, 24'h001234);
    clr = 1'b1;
    cyc(1);
    chk("clrp_time", o_time, 24'h0);
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      chk("clrp_tick", 24'(o_tick), 24'h0);
    end
    chk("clrp_hold", o_time, 24'h0);
    clr = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      chk("clrp_resume_tick", 24'(o_tick), 24'(i == 10));
    end
    chk("clrp_resume_time", o_time, 24'h000001);
    preload(24'h000041);
    en = 1'b1;
    cyc(9);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    chk("lap1_time", o_time, 24'h000042);
    chk("lap1_tick", 24'(o_tick), 24'h1);
    chk("lap1_val", o_lap_time, LAP ? 24'h000041 : 24'h0);
    chk("lap1_valid", 24'(o_lap_valid), 24'(LAP));
    cyc(1);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    chk("lap2_val", o_lap_time, LAP ? 24'h000042 : 24'h0);
    cyc(8);
    chk("lap2_count", o_time, 24'h000043);
    chk("lap2_keep", o_lap_time, LAP ? 24'h000042 : 24'h0);
    chk("lap2_valid", 24'(o_lap_valid), 24'(LAP));
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("lapclr_val", o_lap_time, 24'h0);
    chk("lapclr_valid", 24'(o_lap_valid), 24'h0);
    chk("lapclr_time", o_time, 24'h0);
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("midrst_time", o_time, 24'h0);
    cyc(9);
    chk("midrst_notick", 24'(o_tick), 24'h0);
    cyc(1);
    chk("midrst_tick", 24'(o_tick), 24'h1);
    chk("midrst_time1", o_time, 24'h000001);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/stopwatch_timer.md
Name: stopwatch_timer

Overview:
Downstream time-keeping stage of the stopwatch. Consumes the run-enable and clear outputs of the stopwatch control state machine (o_stout, o_stclear). Divides the system clock to a 1/100 s tick and accumulates elapsed time as BCD digits MM:SS.CC for the display driver. Registered outputs only; no combinational path from inputs to outputs.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
TICK_HZ, 100, count rate in Hz; DIV = CLK_HZ/TICK_HZ, must be an integer >= 2
PW, $clog2(DIV), prescaler width (derived localparam, not overridable)

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst_n  in  1  synchronous active-low reset
i_en  in  1  run enable, from the control FSM's o_stout
i_clr  in  1  clear request, from the control FSM's o_stclear, level-sensitive
i_lap  in  1  lap capture strobe, single-cycle pulse (used only with the optional feature)
o_time  out  24  packed BCD {m_tens, m_ones, s_tens, s_ones, c_tens, c_ones}, 4 bits each
o_tick  out  1  one-cycle pulse on every cycle in which the time advances
o_wrap  out  1  one-cycle pulse when the time rolls over from 59:59.99 to 00:00.00
o_lap_time  out  24  latched lap value, same packing as o_time
o_lap_valid  out  1  high while o_lap_time holds a captured value

Behaviour:
- Reset: when i_rst_n is sampled low at a rising edge, the prescaler, all digits, o_tick, o_wrap, o_lap_time and o_lap_valid go to 0 at that edge. Reset has the highest priority.
- Priority order below reset: i_clr, then i_en.
- i_clr high:
  - Prescaler and all digits go to 0.
  - o_tick and o_wrap are 0.
  - Lap state is cleared.
  - i_en is ignored while i_clr is high.
- i_en high, i_clr low:
  - Prescaler increments each cycle.
  - When the prescaler equals DIV-1, it returns to 0 and a tick occurs on the same edge.
  - The digits advance by one centisecond on that edge, and o_tick is high for the following cycle.
- i_en low, i_clr low: the prescaler and digits hold their values. The prescaler is not reset, so resuming continues the partial period.
- Digit chain, on each tick:
  - c_ones counts 0-9; on carry, c_tens counts 0-9.
  - On carry, s_ones counts 0-9; on carry, s_tens counts 0-5.
  - On carry, m_ones counts 0-9; on carry, m_tens counts 0-5.
  - Each digit increments only when every lower digit is at its maximum.
- Wrap: a tick at 59:59.99 yields 00:00.00, and o_wrap pulses in the same cycle as o_tick. Counting continues.
- Latency:
  - o_time reflects a tick one cycle after the edge where the prescaler equals DIV-1.
  - o_time reflects a clear one cycle after i_clr is sampled high.
- Digits never hold non-BCD values. An out-of-range digit (not reachable in normal operation) resets to 0 on the next tick.
- Reset or clear asserted mid-period discards the partial prescaler count.

Optional Feature:
Macro STOPWATCH_LAP_EN.
- Defined:
  - An i_lap pulse with i_clr low latches the current o_time into o_lap_time and sets o_lap_valid.
  - If i_lap coincides with a tick, the pre-tick value is latched.
  - A later i_lap overwrites the latched value.
  - i_clr or reset clears o_lap_time and o_lap_valid to 0.
- Not defined: the ports remain present, i_lap is ignored, and o_lap_time and o_lap_valid are tied to 0.

Decomposition:
- Package stopwatch_pkg holds:
  - typedef bcd_t (4-bit digit)
  - packed time typedef (24 bits)
  - constants BCD_MAX9 = 9 and BCD_MAX5 = 5
  - constant ZERO_TIME
- One sub-module, bcd_digit: a parameterised mod-(MAX+1) BCD cell.
  - Inputs: clock, reset, clear, carry-in.
  - Outputs: digit, carry-out.
  - Instantiated six times in a ripple-carry chain; carry-out is combinational from (carry-in and digit == MAX).

Test Plan:
- Bench uses CLK_HZ=1000, TICK_HZ=100, so DIV=10.
- Reset: i_rst_n low for 3 cycles with i_en=1 -> o_time=0x000000, o_tick=0, o_wrap=0, o_lap_valid=0 throughout.
- Basic count: i_en=1 for 100 cycles after reset -> exactly 10 o_tick pulses, spaced 10 cycles apart; o_time=0x000010.
- Pause/resume: i_en=1 for 15 cycles, 0 for 20 cycles, then 1 for 5 cycles -> o_time steps 0x000001 then 0x000002; no tick during the pause; second tick 10 enabled cycles after the first.
- Carry chain: run to 0x005999 (00:59.99), one more tick -> 0x010000. Run to 0x595999, one more tick -> 0x000000 with o_wrap and o_tick high in the same cycle.
- Clear priority: i_clr=1 and i_en=1 together at 0x001234 -> o_time=0x000000 next cycle; no tick while i_clr is held; counting resumes from a zero prescaler once i_clr falls.
- Lap (STOPWATCH_LAP_EN defined): i_lap pulse at 0x000042 -> o_lap_time=0x000042 and o_lap_valid=1 while o_time keeps counting. Then i_clr -> o_lap_valid=0 and o_lap_time=0. Without the macro, the same stimulus leaves both lap outputs at 0.
